// File: rtl/cfg_ram_pkg.sv
// Shared types and constants for the configuration RAM write controller.
// Holds the controller state encoding, index/counter widths and a range check.
package cfg_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HWR  = 2'd1,
        CLR  = 2'd2
    } state_t;

    localparam int SEL_W    = 8;
    localparam int WR_CNT_W = 16;

    // Arbiter request/grant bit positions
    localparam int REQ_CLR  = 0;
    localparam int REQ_HOST = 1;

    function automatic logic sel_in_range(input logic [SEL_W-1:0] sel, input int num_rams);
        return {1'b0, sel} < (SEL_W+1)'(num_rams);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester not granted last wins.
// After reset the last grant points at requester 1, so requester 0 goes first.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_reg;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_reg ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last_reg <= grant[1];
        end
    end

endmodule

// File: rtl/cfg_ram_ctrl.sv
// Write controller for a bank of configuration RAMs sharing one broadcast write bus.
// Arbitrates host single-word writes against whole-RAM zero-fill sweeps.
module cfg_ram_ctrl
    import cfg_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_DEPTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RAMS   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  h_valid,
    output logic                  h_ready,
    input  logic [SEL_W-1:0]      h_sel,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [DATA_WIDTH-1:0] h_data,
    input  logic                  clr_req,
    input  logic [SEL_W-1:0]      clr_sel,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  err,
    output logic [SEL_W-1:0]      sram_sel,
    output logic [ADDR_WIDTH-1:0] addr_wr,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] din,
    output logic [WR_CNT_W-1:0]   wr_cnt
);

    localparam int CNT_AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam logic [CNT_AW-1:0] CLR_LAST = CNT_AW'(DATA_DEPTH - 1);

    state_t                state_reg, state_next;
    logic                  clr_pend_reg, clr_pend_next;
    logic [SEL_W-1:0]      clr_sel_reg, clr_sel_next;
    logic [CNT_AW-1:0]     clr_cnt_reg, clr_cnt_next;
    logic [CNT_AW-1:0]     clr_cnt_inc;
    logic                  wr_en_reg, wr_en_next;
    logic [SEL_W-1:0]      sram_sel_reg, sram_sel_next;
    logic [ADDR_WIDTH-1:0] addr_wr_reg, addr_wr_next;
    logic [DATA_WIDTH-1:0] din_reg, din_next;
    logic                  clr_done_reg, clr_done_next;
    logic                  err_reg, err_next;
    logic [WR_CNT_W-1:0]   wr_cnt_reg;

    logic                  is_idle;
    logic                  clr_fresh;
    logic                  clr_want;
    logic [SEL_W-1:0]      clr_sel_eff;
    logic [1:0]            arb_req;
    logic [1:0]            arb_grant;
    logic                  host_acc;

    assign is_idle     = (state_reg == IDLE);
    assign clr_busy    = clr_pend_reg || (state_reg == CLR);
    assign clr_fresh   = clr_req && !clr_busy;
    // A fresh clr_req competes in its own cycle, so a clear can win straight away
    assign clr_want    = clr_pend_reg || clr_fresh;
    assign clr_sel_eff = clr_pend_reg ? clr_sel_reg : clr_sel;
    assign clr_cnt_inc = clr_cnt_reg + 1'b1;

    assign arb_req[REQ_CLR]  = clr_want && is_idle;
    assign arb_req[REQ_HOST] = h_valid && is_idle && rst_n;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req),
        .advance (is_idle),
        .grant   (arb_grant)
    );

    assign h_ready  = rst_n && is_idle && !arb_grant[REQ_CLR];
    assign host_acc = h_valid && h_ready;

    always_comb begin
        state_next    = state_reg;
        clr_pend_next = clr_pend_reg;
        clr_sel_next  = clr_sel_reg;
        clr_cnt_next  = clr_cnt_reg;
        wr_en_next    = 1'b0;
        sram_sel_next = sram_sel_reg;
        addr_wr_next  = addr_wr_reg;
        din_next      = din_reg;
        clr_done_next = 1'b0;
        err_next      = 1'b0;

        if (clr_fresh) begin
            clr_pend_next = 1'b1;
            clr_sel_next  = clr_sel;
        end

        case (state_reg)
            IDLE: begin
                if (arb_grant[REQ_CLR]) begin
                    clr_pend_next = 1'b0;
                    if (sel_in_range(clr_sel_eff, NUM_RAMS)) begin
                        state_next    = CLR;
                        wr_en_next    = 1'b1;
                        sram_sel_next = clr_sel_eff;
                        addr_wr_next  = '0;
                        din_next      = '0;
                        clr_cnt_next  = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (host_acc) begin
                    if (sel_in_range(h_sel, NUM_RAMS)) begin
                        state_next    = HWR;
                        wr_en_next    = 1'b1;
                        sram_sel_next = h_sel;
                        addr_wr_next  = h_addr;
                        din_next      = h_data;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            HWR: begin
                state_next = IDLE;
            end
            CLR: begin
                if (clr_cnt_reg == CLR_LAST) begin
                    state_next    = IDLE;
                    clr_done_next = 1'b1;
                end else begin
                    clr_cnt_next = clr_cnt_inc;
                    wr_en_next   = 1'b1;
                    addr_wr_next = ADDR_WIDTH'(clr_cnt_inc);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            clr_pend_reg <= 1'b0;
            clr_sel_reg  <= '0;
            clr_cnt_reg  <= '0;
            wr_en_reg    <= 1'b0;
            sram_sel_reg <= '0;
            addr_wr_reg  <= '0;
            din_reg      <= '0;
            clr_done_reg <= 1'b0;
            err_reg      <= 1'b0;
            wr_cnt_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            clr_pend_reg <= clr_pend_next;
            clr_sel_reg  <= clr_sel_next;
            clr_cnt_reg  <= clr_cnt_next;
            wr_en_reg    <= wr_en_next;
            sram_sel_reg <= sram_sel_next;
            addr_wr_reg  <= addr_wr_next;
            din_reg      <= din_next;
            clr_done_reg <= clr_done_next;
            err_reg      <= err_next;
            if (wr_en_reg && (wr_cnt_reg != '1)) begin
                wr_cnt_reg <= wr_cnt_reg + 1'b1;
            end
        end
    end

    assign wr_en    = wr_en_reg;
    assign sram_sel = sram_sel_reg;
    assign addr_wr  = addr_wr_reg;
    assign din      = din_reg;
    assign clr_done = clr_done_reg;
    assign err      = err_reg;
    assign wr_cnt   = wr_cnt_reg;

endmodule

// File: tb/tb_cfg_ram_ctrl.sv
// Bench for cfg_ram_ctrl: directed scenarios, then randomized host writes and clears
// checked against a RAM-image model kept at the transaction level.
module tb_cfg_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        h_valid;
    logic        h_ready;
    logic [7:0]  h_sel;
    logic [3:0]  h_addr;
    logic [31:0] h_data;
    logic        clr_req;
    logic [7:0]  clr_sel;
    logic        clr_busy;
    logic        clr_done;
    logic        err;
    logic [7:0]  sram_sel;
    logic [3:0]  addr_wr;
    logic        wr_en;
    logic [31:0] din;
    logic [15:0] wr_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Reference RAM image and the image rebuilt from the observed write bus
    logic [31:0] ref_mem   [0:7][0:15];
    bit          ref_valid [0:7][0:15];
    logic [31:0] obs_mem   [0:255][0:15];
    bit          mon_en = 1'b0;
    int          obs_wr = 0;
    int          obs_err = 0;
    int          obs_done = 0;

    cfg_ram_ctrl #(
        .ADDR_WIDTH (4),
        .DATA_DEPTH (16),
        .DATA_WIDTH (32),
        .NUM_RAMS   (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .h_valid  (h_valid),
        .h_ready  (h_ready),
        .h_sel    (h_sel),
        .h_addr   (h_addr),
        .h_data   (h_data),
        .clr_req  (clr_req),
        .clr_sel  (clr_sel),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .err      (err),
        .sram_sel (sram_sel),
        .addr_wr  (addr_wr),
        .wr_en    (wr_en),
        .din      (din),
        .wr_cnt   (wr_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (wr_en) begin
                obs_mem[sram_sel][addr_wr] <= din;
                obs_wr <= obs_wr + 1;
            end
            if (err)      obs_err  <= obs_err + 1;
            if (clr_done) obs_done <= obs_done + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".h_ready"},  64'(h_ready),  64'd0);
        chk({tag, ".wr_en"},    64'(wr_en),    64'd0);
        chk({tag, ".sram_sel"}, 64'(sram_sel), 64'd0);
        chk({tag, ".addr_wr"},  64'(addr_wr),  64'd0);
        chk({tag, ".din"},      64'(din),      64'd0);
        chk({tag, ".clr_busy"}, 64'(clr_busy), 64'd0);
        chk({tag, ".clr_done"}, 64'(clr_done), 64'd0);
        chk({tag, ".err"},      64'(err),      64'd0);
        chk({tag, ".wr_cnt"},   64'(wr_cnt),   64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        h_valid = 1'b0;
        clr_req = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Holds a host request until accepted (bounded), then releases it after the edge
    task automatic do_host(input logic [7:0] s, input logic [3:0] a, input logic [31:0] d);
        bit ok = 1'b0;
        h_valid = 1'b1;
        h_sel   = s;
        h_addr  = a;
        h_data  = d;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (h_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
            clr_req = 1'b0;
        end
        tick();
        h_valid = 1'b0;
        clr_req = 1'b0;
        chk("host_handshake", 64'(ok), 64'd1);
    endtask

    initial begin
        int writes;
        int done_cnt;
        int bad_sel;
        int low;
        int exp_writes;
        int exp_err;
        int exp_done;

        rst_n = 1'b0;
        h_valid = 1'b0;
        h_sel = '0;
        h_addr = '0;
        h_data = '0;
        clr_req = 1'b0;
        clr_sel = '0;

        // Reset values and first-cycle readiness
        repeat (3) tick();
        chk_reset_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #1;
        chk("ready_after_reset", 64'(h_ready), 64'd1);

        // Single host write: bus driven exactly one cycle after acceptance
        h_valid = 1'b1; h_sel = 8'd3; h_addr = 4'd5; h_data = 32'hDEADBEEF;
        #1;
        chk("hw1.ready", 64'(h_ready), 64'd1);
        tick();
        h_valid = 1'b0;
        chk("hw1.bus", {wr_en, sram_sel, addr_wr, din}, {1'b1, 8'd3, 4'd5, 32'hDEADBEEF});
        #1;
        chk("hw1.ready_in_hwr", 64'(h_ready), 64'd0);
        tick();
        chk("hw1.wr_en_off", 64'(wr_en), 64'd0);
        chk("hw1.hold", {sram_sel, addr_wr, din}, {8'd3, 4'd5, 32'hDEADBEEF});
        chk("hw1.wr_cnt", 64'(wr_cnt), 64'd1);
        $display("txn host_write sel=3 addr=5 data=deadbeef");

        // Clear of RAM 2: 16 gapless zero writes, then done with busy falling
        clr_req = 1'b1; clr_sel = 8'd2;
        #1;
        chk("clr2.ready_low", 64'(h_ready), 64'd0);
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("clr2.w%0d", i), {wr_en, sram_sel, addr_wr, din, clr_busy, clr_done},
                {1'b1, 8'd2, 4'(i), 32'd0, 1'b1, 1'b0});
            tick();
        end
        chk("clr2.done", {clr_done, clr_busy, wr_en}, {1'b1, 1'b0, 1'b0});
        chk("clr2.wr_cnt", 64'(wr_cnt), 64'd17);
        tick();
        chk("clr2.done_pulse", 64'(clr_done), 64'd0);
        $display("txn clear sel=2");

        // Second clr_req during a sweep is ignored
        clr_req = 1'b1; clr_sel = 8'd1;
        tick();
        clr_req = 1'b0;
        writes = 0; done_cnt = 0; bad_sel = 0;
        for (int k = 0; k < 30; k++) begin
            if (wr_en) begin
                writes++;
                if (sram_sel != 8'd1) bad_sel++;
            end
            if (clr_done) done_cnt++;
            clr_req = (k == 5);
            clr_sel = 8'd4;
            tick();
        end
        clr_req = 1'b0;
        chk("clr_dup.writes", 64'(writes), 64'd16);
        chk("clr_dup.done", 64'(done_cnt), 64'd1);
        chk("clr_dup.sel", 64'(bad_sel), 64'd0);
        chk("clr_dup.wr_cnt", 64'(wr_cnt), 64'd33);
        $display("txn clear sel=1 with ignored second request");

        // Out-of-range host select: handshake completes, no write, err pulse
        h_valid = 1'b1; h_sel = 8'd8; h_addr = 4'd1; h_data = 32'h1234;
        #1;
        chk("bad_sel.ready", 64'(h_ready), 64'd1);
        tick();
        h_valid = 1'b0;
        chk("bad_sel.wr_en", 64'(wr_en), 64'd0);
        chk("bad_sel.err", 64'(err), 64'd1);
        tick();
        chk("bad_sel.err_pulse", 64'(err), 64'd0);
        chk("bad_sel.wr_cnt", 64'(wr_cnt), 64'd33);
        $display("txn host_write sel=8 rejected");

        // Clear and host arriving together right after reset: clear first
        do_reset();
        h_valid = 1'b1; h_sel = 8'd5; h_addr = 4'd9; h_data = 32'hA5A55A5A;
        clr_req = 1'b1; clr_sel = 8'd6;
        low = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (h_ready) break;
            low++;
            tick();
            clr_req = 1'b0;
        end
        tick();
        h_valid = 1'b0;
        chk("contend.ready_low_cycles", 64'(low), 64'd17);
        chk("contend.host_bus", {wr_en, sram_sel, addr_wr, din}, {1'b1, 8'd5, 4'd9, 32'hA5A55A5A});
        tick();
        chk("contend.wr_cnt", 64'(wr_cnt), 64'd17);
        $display("txn contention clear sel=6 then host sel=5");

        // Reset asserted during the 7th clear write aborts the sweep
        clr_req = 1'b1; clr_sel = 8'd0;
        tick();
        clr_req = 1'b0;
        repeat (6) tick();
        chk("abort.pre", {wr_en, addr_wr}, {1'b1, 4'd6});
        rst_n = 1'b0;
        #1;
        chk_reset_outs("abort");
        done_cnt = 0;
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (clr_done || wr_en) done_cnt++;
        end
        chk("abort.no_done_or_write", 64'(done_cnt), 64'd0);
        chk("abort.wr_cnt", 64'(wr_cnt), 64'd0);
        $display("txn clear aborted by reset");

        // Randomized mix of host writes and clears against the RAM-image model
        do_reset();
        mon_en = 1'b1;
        exp_writes = 0; exp_err = 0; exp_done = 0;
        for (int it = 0; it < 30; it++) begin
            int op;
            logic [7:0] hs, cs;
            logic [3:0] ha;
            logic [31:0] hd;
            op = $urandom_range(0, 2);
            hs = 8'($urandom_range(0, 9));
            cs = 8'((hs + 1 + $urandom_range(0, 7)) % 10);
            ha = 4'($urandom_range(0, 15));
            hd = $urandom;
            if (op != 0) begin
                if (cs < 8) begin
                    exp_writes += 16;
                    exp_done++;
                    for (int a = 0; a < 16; a++) begin
                        ref_mem[cs][a] = '0;
                        ref_valid[cs][a] = 1'b1;
                    end
                end else begin
                    exp_err++;
                end
                clr_req = 1'b1;
                clr_sel = cs;
            end
            if (op != 1) begin
                if (hs < 8) begin
                    exp_writes++;
                    ref_mem[hs][ha] = hd;
                    ref_valid[hs][ha] = 1'b1;
                end else begin
                    exp_err++;
                end
                do_host(hs, ha, hd);
            end else begin
                tick();
                clr_req = 1'b0;
            end
            repeat (20) tick();
            $display("txn rand %0d op=%0d host_sel=%0d addr=%0d data=%08h clr_sel=%0d",
                     it, op, hs, ha, hd, cs);
        end
        chk("rand.wr_cnt", 64'(wr_cnt), 64'(exp_writes));
        chk("rand.writes_seen", 64'(obs_wr), 64'(exp_writes));
        chk("rand.err_pulses", 64'(obs_err), 64'(exp_err));
        chk("rand.done_pulses", 64'(obs_done), 64'(exp_done));
        for (int s = 0; s < 8; s++) begin
            for (int a = 0; a < 16; a++) begin
                if (ref_valid[s][a]) begin
                    chk($sformatf("rand.mem[%0d][%0d]", s, a), 64'(obs_mem[s][a]), 64'(ref_mem[s][a]));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cfg_ram_ctrl.md
CFG_RAM_CTRL -- requirements
Module: cfg_ram_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: write-address width of every attached configuration RAM.
REQ-002 Parameter DATA_DEPTH, default 16: number of words per RAM swept by a clear; must be at most 2**ADDR_WIDTH.
REQ-003 Parameter DATA_WIDTH, default 32: configuration word width.
REQ-004 Parameter NUM_RAMS, default 8: number of valid RAM indices, from 1 to 256.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 h_valid  in  1  host write request valid.
REQ-008 h_ready  out  1  host write request accepted when h_valid and h_ready are both high.
REQ-009 h_sel  in  8  target RAM index.
REQ-010 h_addr  in  ADDR_WIDTH  target word address.
REQ-011 h_data  in  DATA_WIDTH  write data.
REQ-012 clr_req  in  1  single-cycle request to zero-fill one RAM.
REQ-013 clr_sel  in  8  RAM index to clear; sampled together with clr_req.
REQ-014 clr_busy  out  1  a clear is pending or in progress.
REQ-015 clr_done  out  1  one-cycle pulse when a clear completes.
REQ-016 err  out  1  one-cycle pulse when a request names an index of NUM_RAMS or above.
REQ-017 sram_sel  out  8  broadcast RAM select.
REQ-018 addr_wr  out  ADDR_WIDTH  broadcast write address.
REQ-019 wr_en  out  1  broadcast write strobe.
REQ-020 din  out  DATA_WIDTH  broadcast write data.
REQ-021 wr_cnt  out  16  count of RAM writes issued, saturating at 16'hFFFF.

Function
REQ-022 The controller SHALL run a three-state machine with states IDLE, HWR and CLR.
REQ-023 All RAM-side outputs (sram_sel, addr_wr, wr_en, din) SHALL be registered.
REQ-024 h_ready SHALL be high only in IDLE, and only when the arbiter does not grant a pending clear in that cycle.
REQ-025 A host request accepted in cycle N SHALL drive wr_en=1 with its sel, addr and data in cycle N+1 (state HWR); the state returns to IDLE in cycle N+2.
REQ-026 A clr_req SHALL set a clear-pending latch holding clr_sel; any clr_req while clr_busy is high SHALL be ignored.
REQ-027 When both a host request and a clear are pending in IDLE, the 2-way round-robin arbiter SHALL grant the requester not granted last; after reset, the clear has priority.
REQ-028 A clear SHALL be granted in cycle N and then issue wr_en=1 with din=0 for addresses 0 to DATA_DEPTH-1 in cycles N+1 to N+DATA_DEPTH, with no gaps.
REQ-029 clr_done SHALL pulse in cycle N+DATA_DEPTH+1, clr_busy SHALL fall in that same cycle, and the state SHALL return to IDLE.
REQ-030 A request whose index is NUM_RAMS or above SHALL be consumed (the host handshake completes, or the clear latch is released) without asserting wr_en, and SHALL pulse err in the following cycle; a rejected clear SHALL NOT pulse clr_done.
REQ-031 The clear address counter SHALL be DATA_DEPTH-sized and SHALL NOT wrap past DATA_DEPTH-1.
REQ-032 wr_cnt SHALL increment by one on every cycle with wr_en=1, and SHALL hold at 16'hFFFF once reached.
REQ-033 When wr_en=0, sram_sel, addr_wr and din SHALL hold their previous values.

Reset
REQ-034 While rst_n is low, the controller SHALL immediately enter IDLE and drive: h_ready=0, wr_en=0, sram_sel=0, addr_wr=0, din=0, clr_busy=0, clr_done=0, err=0, wr_cnt=0; the pending latch SHALL clear and the round-robin pointer SHALL return to clear-priority.
REQ-035 A reset asserted mid-clear SHALL abort the sweep with no clr_done pulse.
REQ-036 h_ready SHALL assert in the first clock cycle after rst_n deasserts.

Structure
REQ-037 Package cfg_ram_pkg SHALL hold the state enum (IDLE, HWR, CLR), the 8-bit RAM-index width constant, and the width of wr_cnt.
REQ-038 The round-robin arbiter SHALL be a sub-module, rr_arb2, with 2 request inputs, a one-hot grant output, and an internal last-grant register.

Verification
REQ-039 Reset release, then a host write with sel=3, addr=5, data=32'hDEADBEEF -> exactly one cycle later wr_en=1, sram_sel=3, addr_wr=5, din=32'hDEADBEEF; then wr_cnt=1.
REQ-040 clr_req with clr_sel=2 -> 16 consecutive wr_en cycles on addresses 0 to 15 with din=0, clr_done in the next cycle, and wr_cnt incremented by 16.
REQ-041 A clear and a host write arriving in the same cycle directly after reset -> the clear runs first and h_ready stays low for 17 cycles; the host write then issues.
REQ-042 A second clr_req during an active clear -> it is ignored, exactly 16 writes occur, and exactly one clr_done pulse is seen.
REQ-043 A host write with sel=8 (NUM_RAMS=8) -> the handshake completes, there is no wr_en, and err pulses once.
REQ-044 rst_n pulled low during the 7th clear write -> all outputs drop to their reset values at once, no clr_done occurs, and wr_cnt=0.
